ddr3_rd_arbiter: RTL and testbench

Shares one AXI4 read port (AR + R channels) to the DDR3 memory controller between `C_NUM_REQ` read requesters, such as the traffic generator and future DMA engines. It arbitrates round-robin and allows one outstanding burst at a time. Returned R beats are steered to the granted requester. Burst-length and ID mismatches are flagged in sticky error bits.

---
 rtl/ddr3_axi_pkg.sv | 25 ++
 rtl/ddr3_rd_arbiter_rr_arbiter.sv | 37 +++
 rtl/ddr3_rd_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ddr3_rd_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_axi_pkg.sv
// -----------------------------------------------------------------------------
// ddr3_axi_pkg
// Shared types and constants for the DDR3 AXI read-path blocks.
//   axi_rd_state_e : read arbiter FSM states (IDLE, ADDR, DATA)
//   AXI_BURST_INCR : AXI ARBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  : AXI RRESP encoding for a normal response
//   axi_size()     : ARSIZE for a given data-bus width in bits
// -----------------------------------------------------------------------------
package ddr3_axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } axi_rd_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // ARSIZE is log2 of the number of bytes per beat.
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/ddr3_rd_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first requesting index strictly
// after last_grant, wrapping cyclically.
//   req        in  N   request vector, one bit per requester
//   last_grant in  GW  index granted most recently
//   grant      out GW  chosen index (valid only when any_req is set)
//   any_req    out 1   at least one request bit is set
// -----------------------------------------------------------------------------
module rr_arbiter
    import ddr3_axi_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [GW-1:0] grant,
    output logic          any_req
);

    int cand_s;

    // Walk offsets from farthest to nearest so the nearest requester after
    // last_grant is written last and therefore wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        cand_s  = 0;
        for (int k = N; k >= 1; k--) begin
            cand_s = int'(last_grant) + k;
            cand_s = (cand_s >= N) ? (cand_s - N) : cand_s;
            grant  = req[cand_s] ? GW'(cand_s) : grant;
        end
    end

endmodule

// File: rtl/ddr3_rd_arbiter.sv
// -----------------------------------------------------------------------------
// ddr3_rd_arbiter
// Shares one AXI4 read port (AR + R) of the DDR3 controller between C_NUM_REQ
// requesters. Round-robin grant, one outstanding burst at a time; R beats are
// steered to the granted requester. Burst-length and RID mismatches are
// recorded in sticky error bits cleared only by reset.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   S_axi_ar*               per-requester AR channel (requester i at slice i)
//   S_axi_r*                R channel; data/resp/last broadcast, rvalid one-hot
//   M_axi_ar*               AR channel toward the memory controller
//   M_axi_r*                R channel from the memory controller
//   err_len                 sticky: RLAST position disagreed with ARLEN
//   err_rid                 sticky: RID differed from the grant index
// -----------------------------------------------------------------------------
module ddr3_rd_arbiter
    import ddr3_axi_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 3,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_NUM_REQ          = 2
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [C_NUM_REQ*C_S_AXI_ADDR_WIDTH-1:0] S_axi_araddr,
    input  logic [C_NUM_REQ*8-1:0]                  S_axi_arlen,
    input  logic [C_NUM_REQ-1:0]                    S_axi_arvalid,
    output logic [C_NUM_REQ-1:0]                    S_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]           S_axi_rdata,
    output logic [1:0]                              S_axi_rresp,
    output logic                                    S_axi_rlast,
    output logic [C_NUM_REQ-1:0]                    S_axi_rvalid,
    input  logic [C_NUM_REQ-1:0]                    S_axi_rready,
    output logic [C_S_AXI_ID_WIDTH-1:0]             M_axi_arid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]           M_axi_araddr,
    output logic [7:0]                              M_axi_arlen,
    output logic [2:0]                              M_axi_arsize,
    output logic [1:0]                              M_axi_arburst,
    output logic                                    M_axi_arvalid,
    input  logic                                    M_axi_arready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]             M_axi_rid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]           M_axi_rdata,
    input  logic [1:0]                              M_axi_rresp,
    input  logic                                    M_axi_rlast,
    input  logic                                    M_axi_rvalid,
    output logic                                    M_axi_rready,
    output logic                                    err_len,
    output logic                                    err_rid
);

    localparam int GW = $clog2(C_NUM_REQ);

    axi_rd_state_e                  state_r;
    logic [GW-1:0]                  grant_r;
    logic [GW-1:0]                  last_grant_r;
    logic                           m_arvalid_r;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  araddr_r;
    logic [7:0]                     arlen_r;
    logic [8:0]                     beat_cnt_r;
    logic                           err_len_r;
    logic                           err_rid_r;

    logic [GW-1:0]                  arb_grant_s;
    logic                           arb_any_s;
    logic [C_S_AXI_ID_WIDTH-1:0]    arid_s;
    logic                           beat_s;
    logic                           len_bad_s;
    logic                           rid_bad_s;

    rr_arbiter #(
        .N  (C_NUM_REQ),
        .GW (GW)
    ) u_rr_arbiter (
        .req        (S_axi_arvalid),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .any_req    (arb_any_s)
    );

    // Grant index zero-extended to the AXI ID width.
    always_comb begin
        arid_s           = '0;
        arid_s[GW-1:0]   = grant_r;
    end

    // Handshake steering: AR accept and R valid/ready follow the grant only.
    always_comb begin
        S_axi_arready = '0;
        S_axi_rvalid  = '0;
        M_axi_rready  = 1'b0;
        case (state_r)
            ADDR: begin
                S_axi_arready[grant_r] = m_arvalid_r & M_axi_arready;
            end
            DATA: begin
                S_axi_rvalid[grant_r] = M_axi_rvalid;
                M_axi_rready          = S_axi_rready[grant_r];
            end
            default: begin
                S_axi_arready = '0;
                S_axi_rvalid  = '0;
                M_axi_rready  = 1'b0;
            end
        endcase
    end

    // Per-beat qualifiers; the length check fires when RLAST and "counter at
    // ARLEN" disagree in either direction.
    always_comb begin
        beat_s    = (state_r == DATA) & M_axi_rvalid & M_axi_rready;
        len_bad_s = M_axi_rlast ^ (beat_cnt_r == {1'b0, arlen_r});
        rid_bad_s = (M_axi_rid != arid_s);
    end

    // Arbiter FSM: grant/latch in IDLE, present AR in ADDR, count beats in DATA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= GW'(C_NUM_REQ - 1);
            m_arvalid_r  <= 1'b0;
            araddr_r     <= '0;
            arlen_r      <= 8'd0;
            beat_cnt_r   <= 9'd0;
            err_len_r    <= 1'b0;
            err_rid_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (arb_any_s) begin
                        grant_r     <= arb_grant_s;
                        araddr_r    <= S_axi_araddr[int'(arb_grant_s)*C_S_AXI_ADDR_WIDTH +: C_S_AXI_ADDR_WIDTH];
                        arlen_r     <= S_axi_arlen[int'(arb_grant_s)*8 +: 8];
                        beat_cnt_r  <= 9'd0;
                        m_arvalid_r <= 1'b1;
                        state_r     <= ADDR;
                    end
                end
                ADDR: begin
                    if (M_axi_arready) begin
                        m_arvalid_r <= 1'b0;
                        state_r     <= DATA;
                    end
                end
                DATA: begin
                    if (beat_s) begin
                        // Saturate so an overlong burst cannot wrap the count.
                        beat_cnt_r <= (beat_cnt_r == 9'h1FF) ? beat_cnt_r : beat_cnt_r + 9'd1;
                        if (len_bad_s) begin
                            err_len_r <= 1'b1;
                        end
                        if (rid_bad_s) begin
                            err_rid_r <= 1'b1;
                        end
                        if (M_axi_rlast) begin
                            last_grant_r <= grant_r;
                            state_r      <= IDLE;
                        end
                    end
                end
                default: begin
                    m_arvalid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign M_axi_arid    = arid_s;
    assign M_axi_araddr  = araddr_r;
    assign M_axi_arlen   = arlen_r;
    assign M_axi_arsize  = axi_size(C_S_AXI_DATA_WIDTH);
    assign M_axi_arburst = AXI_BURST_INCR;
    assign M_axi_arvalid = m_arvalid_r;

    assign S_axi_rdata   = M_axi_rdata;
    assign S_axi_rresp   = M_axi_rresp;
    assign S_axi_rlast   = M_axi_rlast;

    assign err_len       = err_len_r;
    assign err_rid       = err_rid_r;

endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr3_rd_arbiter
// Directed bench for ddr3_rd_arbiter with a beat scoreboard: every beat the
// memory side offers is queued, and popped/compared when the requester side
// completes the handshake.
// -----------------------------------------------------------------------------
module tb_ddr3_rd_arbiter;

    localparam int N   = 2;
    localparam int IDW = 3;
    localparam int AW  = 32;
    localparam int DW  = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N*AW-1:0]   s_araddr;
    logic [N*8-1:0]    s_arlen;
    logic [N-1:0]      s_arvalid;
    logic [N-1:0]      s_arready;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic [N-1:0]      s_rvalid;
    logic [N-1:0]      s_rready;
    logic [IDW-1:0]    m_arid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready;
    logic [IDW-1:0]    m_rid;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;
    logic              err_len;
    logic              err_rid;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    beat_t sb[$];

    always #5 clk = ~clk;

    ddr3_rd_arbiter #(
        .C_S_AXI_ID_WIDTH   (IDW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_S_AXI_DATA_WIDTH (DW),
        .C_NUM_REQ          (N)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .S_axi_araddr  (s_araddr),
        .S_axi_arlen   (s_arlen),
        .S_axi_arvalid (s_arvalid),
        .S_axi_arready (s_arready),
        .S_axi_rdata   (s_rdata),
        .S_axi_rresp   (s_rresp),
        .S_axi_rlast   (s_rlast),
        .S_axi_rvalid  (s_rvalid),
        .S_axi_rready  (s_rready),
        .M_axi_arid    (m_arid),
        .M_axi_araddr  (m_araddr),
        .M_axi_arlen   (m_arlen),
        .M_axi_arsize  (m_arsize),
        .M_axi_arburst (m_arburst),
        .M_axi_arvalid (m_arvalid),
        .M_axi_arready (m_arready),
        .M_axi_rid     (m_rid),
        .M_axi_rdata   (m_rdata),
        .M_axi_rresp   (m_rresp),
        .M_axi_rlast   (m_rlast),
        .M_axi_rvalid  (m_rvalid),
        .M_axi_rready  (m_rready),
        .err_len       (err_len),
        .err_rid       (err_rid)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_m_arvalid"}, 64'(m_arvalid), 64'd0);
        check_val({tag, "_m_rready"},  64'(m_rready),  64'd0);
        check_val({tag, "_s_arready"}, 64'(s_arready), 64'd0);
        check_val({tag, "_s_rvalid"},  64'(s_rvalid),  64'd0);
        check_val({tag, "_err_len"},   64'(err_len),   64'd0);
        check_val({tag, "_err_rid"},   64'(err_rid),   64'd0);
        check_val({tag, "_m_araddr"},  64'(m_araddr),  64'd0);
        check_val({tag, "_m_arlen"},   64'(m_arlen),   64'd0);
    endtask

    // Starts on the negedge before the AR should appear; returns at negedge+1
    // of the cycle after acceptance.
    task automatic addr_phase(input int g, input logic [31:0] addr, input logic [7:0] len, input int delay);
        int w      = 0;
        int pulses = 0;
        @(negedge clk);
        while (!m_arvalid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("ar_latency", 64'(w), 64'd0);
        if (m_arvalid) begin
            check_val("m_arid",    64'(m_arid),    64'(g));
            check_val("m_araddr",  64'(m_araddr),  64'(addr));
            check_val("m_arlen",   64'(m_arlen),   64'(len));
            check_val("m_arsize",  64'(m_arsize),  64'd3);
            check_val("m_arburst", 64'(m_arburst), 64'd1);
            for (int i = 0; i < delay; i++) begin
                m_arready = 1'b0;
                #1;
                if (s_arready != '0) pulses++;
                check_val("arvalid_hold", 64'(m_arvalid), 64'd1);
                @(negedge clk);
            end
            m_arready = 1'b1;
            #1;
            if (s_arready != '0) pulses++;
            check_val("s_arready_grant", 64'(s_arready), 64'(1 << g));
            @(negedge clk);
            m_arready = 1'b0;
            #1;
            if (s_arready != '0) pulses++;
            check_val("arready_pulses", 64'(pulses), 64'd1);
            check_val("arvalid_drop", 64'(m_arvalid), 64'd0);
        end
    endtask

    // Offers last_at beats; abort_at >= 0 pulls reset during that beat instead.
    task automatic data_phase(input int g, input logic [63:0] base, input int last_at,
                              input logic [2:0] rid, input bit toggle, input int abort_at);
        int    sent   = 0;
        int    cyc    = 0;
        bit    pushed = 1'b0;
        beat_t exp_b;
        beat_t new_b;
        while (sent < last_at && cyc < 4 * last_at + 20) begin
            if (cyc > 0) @(negedge clk);
            if (abort_at >= 0 && sent == abort_at) begin
                m_rvalid = 1'b1;
                reset_n  = 1'b0;
                #1;
                check_reset_outputs("rst_mid");
                sb.delete();
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
                return;
            end
            m_rvalid = 1'b1;
            m_rdata  = base + 64'(sent);
            m_rlast  = (sent + 1 == last_at);
            m_rresp  = 2'(sent);
            m_rid    = rid;
            if (!pushed) begin
                new_b.data = m_rdata;
                new_b.last = m_rlast;
                new_b.resp = m_rresp;
                sb.push_back(new_b);
                pushed = 1'b1;
            end
            s_rready = '1;
            if (toggle) s_rready[g] = (cyc % 2 == 0);
            #1;
            check_val("m_rready_mirror", 64'(m_rready), 64'(s_rready[g]));
            check_val("s_rvalid_onehot", 64'(s_rvalid), 64'(1 << g));
            if (m_rready) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_b = sb.pop_front();
                    check_val("rdata", 64'(s_rdata), exp_b.data);
                    check_val("rlast", 64'(s_rlast), 64'(exp_b.last));
                    check_val("rresp", 64'(s_rresp), 64'(exp_b.resp));
                end
                sent++;
                pushed = 1'b0;
            end
            cyc++;
            @(posedge clk);
        end
        check_val("beats_done", 64'(sent), 64'(last_at));
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '1;
        #1;
        check_val("s_rvalid_idle", 64'(s_rvalid), 64'd0);
        check_val("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_burst(input int g, input logic [31:0] addr, input logic [7:0] len, input int delay,
                             input int last_at, input logic [2:0] rid, input bit toggle,
                             input logic [63:0] base, input int abort_at);
        @(negedge clk);
        s_araddr[g*AW +: AW] = addr;
        s_arlen[g*8 +: 8]    = len;
        s_arvalid            = '0;
        s_arvalid[g]         = 1'b1;
        @(posedge clk);
        addr_phase(g, addr, len, delay);
        s_arvalid[g] = 1'b0;
        data_phase(g, base, last_at, rid, toggle, abort_at);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rr_addr [2];
        reset_n   = 1'b0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arvalid = '0;
        s_rready  = '1;
        m_arready = 1'b0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;

        // Basic burst from requester 0.
        run_burst(0, 32'h0100_0000, 8'd7, 0, 8, 3'd0, 1'b0, 64'h0, -1);
        check_val("err_len_basic", 64'(err_len), 64'd0);
        check_val("err_rid_basic", 64'(err_rid), 64'd0);

        // Delayed AR accept plus toggling rready; data 0..7.
        run_burst(1, 32'h0200_0040, 8'd7, 5, 8, 3'd1, 1'b1, 64'h0, -1);
        check_val("err_len_toggle", 64'(err_len), 64'd0);

        // Single-beat and maximum-length bursts.
        run_burst(0, 32'h0000_1000, 8'd0, 0, 1, 3'd0, 1'b0, 64'hA0, -1);
        check_val("err_len_len0", 64'(err_len), 64'd0);
        run_burst(1, 32'h0300_0000, 8'd255, 0, 256, 3'd1, 1'b0, 64'h1000, -1);
        check_val("err_len_len255", 64'(err_len), 64'd0);

        // Early RLAST, then a wrong RID on a clean-length burst.
        run_burst(1, 32'h0400_0000, 8'd3, 1, 2, 3'd1, 1'b0, 64'h2000, -1);
        check_val("err_len_early", 64'(err_len), 64'd1);
        check_val("err_rid_clean", 64'(err_rid), 64'd0);
        run_burst(0, 32'h0500_0000, 8'd1, 0, 2, 3'd1, 1'b0, 64'h3000, -1);
        check_val("err_rid_bad", 64'(err_rid), 64'd1);
        check_val("err_len_sticky", 64'(err_len), 64'd1);

        // Reset during beat 4 of 8.
        run_burst(1, 32'h0600_0000, 8'd7, 0, 8, 3'd1, 1'b0, 64'h4000, 3);

        // Both requesters active after reset: grants 0,1,0,1.
        @(negedge clk);
        reset_n   = 1'b1;
        rr_addr[0] = 32'h2000_0000;
        rr_addr[1] = 32'h3000_0000;
        s_araddr  = {rr_addr[1], rr_addr[0]};
        s_arlen   = {8'd1, 8'd1};
        s_arvalid = 2'b11;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            addr_phase(i % 2, rr_addr[i % 2], 8'd1, 0);
            rr_addr[i % 2] = rr_addr[i % 2] + 32'h100;
            s_araddr = {rr_addr[1], rr_addr[0]};
            data_phase(i % 2, 64'h5000 + 64'(i * 16), 2, 3'(i % 2), 1'b0, -1);
        end
        s_arvalid = '0;
        check_val("err_len_after_rst", 64'(err_len), 64'd0);
        check_val("err_rid_after_rst", 64'(err_rid), 64'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
